// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: ALU control codes,
// main-control ALU op classes, R-type funct codes, EX/MEM bundle.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_MEM  = 2'b00;
  localparam logic [1:0] ALUOP_BEQ  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_ADDI = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  typedef struct packed {
    logic [1:0]  wb;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        zero;
    logic [31:0] branch_target;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  dest_reg;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_alu_core.sv
// Combinational 32-bit ALU; overflow is silently discarded.
// Codes without an operation produce zero.
module alu_core
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctrl,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    unique case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control, operand/dest muxes, branch adder
// and the EX/MEM pipeline register (one-cycle latency, no stall).
module ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic [2:0]  mem_in,
  input  logic        reg_dst,
  input  logic        alu_src,
  input  logic [1:0]  alu_op,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] imm_ext,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [1:0]  wb_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        branch_out,
  output logic        zero_out,
  output logic [31:0] branch_target_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] write_data_out,
  output logic [4:0]  dest_reg_out
);

  logic [2:0]  alu_ctrl;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  ex_mem_t     ex_mem_d;
  ex_mem_t     ex_mem_q;

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_MEM:  alu_ctrl = ALU_ADD;
      ALUOP_BEQ:  alu_ctrl = ALU_SUB;
      ALUOP_ADDI: alu_ctrl = ALU_ADD;
      ALUOP_RTYP: begin
        unique case (imm_ext[5:0])
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          FUNCT_NOR: alu_ctrl = ALU_NOR;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  assign op_b = alu_src ? imm_ext : read_data2;

  alu_core u_alu (
    .a      (read_data1),
    .b      (op_b),
    .ctrl   (alu_ctrl),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    ex_mem_d               = '0;
    ex_mem_d.wb            = wb_in;
    ex_mem_d.mem_read      = mem_in[2];
    ex_mem_d.mem_write     = mem_in[1];
    ex_mem_d.branch        = mem_in[0];
    ex_mem_d.zero          = alu_zero;
    ex_mem_d.branch_target =
      pc_plus4 + {imm_ext[29:0], 2'b00};
    ex_mem_d.alu_result    = alu_res;
    ex_mem_d.write_data    = read_data2;
    ex_mem_d.dest_reg      = reg_dst ? rd : rt;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_mem_q <= '0;
    else     ex_mem_q <= ex_mem_d;
  end

  assign wb_out            = ex_mem_q.wb;
  assign mem_read_out      = ex_mem_q.mem_read;
  assign mem_write_out     = ex_mem_q.mem_write;
  assign branch_out        = ex_mem_q.branch;
  assign zero_out          = ex_mem_q.zero;
  assign branch_target_out = ex_mem_q.branch_target;
  assign alu_result_out    = ex_mem_q.alu_result;
  assign write_data_out    = ex_mem_q.write_data;
  assign dest_reg_out      = ex_mem_q.dest_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes hand-computed
// EX/MEM contents, monitor pops and compares after each edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_in;
  logic [2:0]  mem_in;
  logic        reg_dst, alu_src;
  logic [1:0]  alu_op;
  logic [31:0] pc_plus4, read_data1, read_data2, imm_ext;
  logic [4:0]  rt, rd;
  logic [1:0]  wb_out;
  logic        mem_read_out, mem_write_out, branch_out, zero_out;
  logic [31:0] branch_target_out, alu_result_out, write_data_out;
  logic [4:0]  dest_reg_out;

  typedef struct {
    logic        rst;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic        reg_dst, alu_src;
    logic [1:0]  alu_op;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rt, rd;
  } vin_t;

  typedef struct {
    string       name;
    logic [1:0]  wb;
    logic        mr, mw, br, zero;
    logic [31:0] bt, res, wd;
    logic [4:0]  dest;
  } vexp_t;

  vexp_t sb[$];
  int checks = 0;
  int failures = 0;
  bit done = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .wb_in(wb_in), .mem_in(mem_in),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
    .pc_plus4(pc_plus4), .read_data1(read_data1),
    .read_data2(read_data2), .imm_ext(imm_ext), .rt(rt), .rd(rd),
    .wb_out(wb_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .branch_out(branch_out),
    .zero_out(zero_out), .branch_target_out(branch_target_out),
    .alu_result_out(alu_result_out),
    .write_data_out(write_data_out), .dest_reg_out(dest_reg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, string f,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h expected=%h", n, f, act, exp);
    end
  endtask

  task automatic issue(vin_t v, vexp_t e);
    @(negedge clk);
    rst = v.rst; wb_in = v.wb; mem_in = v.mem;
    reg_dst = v.reg_dst; alu_src = v.alu_src; alu_op = v.alu_op;
    pc_plus4 = v.pc; read_data1 = v.a; read_data2 = v.b;
    imm_ext = v.imm; rt = v.rt; rd = v.rd;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      vexp_t e;
      e = sb.pop_front();
      chk(e.name, "wb", 32'(wb_out), 32'(e.wb));
      chk(e.name, "mem_read", 32'(mem_read_out), 32'(e.mr));
      chk(e.name, "mem_write", 32'(mem_write_out), 32'(e.mw));
      chk(e.name, "branch", 32'(branch_out), 32'(e.br));
      chk(e.name, "zero", 32'(zero_out), 32'(e.zero));
      chk(e.name, "target", branch_target_out, e.bt);
      chk(e.name, "result", alu_result_out, e.res);
      chk(e.name, "wdata", write_data_out, e.wd);
      chk(e.name, "dest", 32'(dest_reg_out), 32'(e.dest));
    end
  end

  vin_t  vi[$];
  vexp_t ve[$];

  task automatic add(vin_t v, vexp_t e);
    vi.push_back(v);
    ve.push_back(e);
  endtask

  initial begin
    rst = 1'b1; wb_in = '0; mem_in = '0; reg_dst = 0; alu_src = 0;
    alu_op = '0; pc_plus4 = '0; read_data1 = '0; read_data2 = '0;
    imm_ext = '0; rt = '0; rd = '0;

    // rst, wb, mem, rdst, src, op, pc, a, b, imm, rt, rd
    add('{1, 2'b11, 3'b111, 1, 1, 2'b10, 32'h44, 32'h5, 32'h7,
          32'h20, 5'd4, 5'd3},
        '{"rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0});
    add('{1, 2'b11, 3'b111, 1, 1, 2'b10, 32'h44, 32'h5, 32'h7,
          32'h20, 5'd4, 5'd3},
        '{"rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h100, 32'h5, 32'h7,
          32'h20, 5'd4, 5'd3},
        '{"add", 2'b10, 0, 0, 0, 0, 32'h180, 32'd12, 32'h7, 5'd3});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'h1,
          32'h22, 5'd4, 5'd8},
        '{"sub", 2'b10, 0, 0, 0, 0, 32'h88, 32'hFFFF_FFFE, 32'h1,
          5'd8});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'h1,
          32'h2A, 5'd4, 5'd9},
        '{"slt", 2'b10, 0, 0, 0, 0, 32'hA8, 32'h1, 32'h1, 5'd9});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'h1,
          32'h24, 5'd4, 5'd10},
        '{"and", 2'b10, 0, 0, 0, 0, 32'h90, 32'h1, 32'h1, 5'd10});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'h1,
          32'h25, 5'd4, 5'd11},
        '{"or", 2'b10, 0, 0, 0, 0, 32'h94, 32'hFFFF_FFFF, 32'h1,
          5'd11});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'h1,
          32'h27, 5'd4, 5'd12},
        '{"nor", 2'b10, 0, 0, 0, 1, 32'h9C, 32'h0, 32'h1, 5'd12});
    add('{0, 2'b11, 3'b100, 0, 1, 2'b00, 32'h200, 32'h100, 32'hDEAD,
          32'hFFFF_FFFC, 5'd9, 5'd5},
        '{"lw", 2'b11, 1, 0, 0, 0, 32'h1F0, 32'hFC, 32'hDEAD, 5'd9});
    add('{0, 2'b00, 3'b001, 0, 0, 2'b01, 32'h40, 32'h1234, 32'h1234,
          32'hFFFF_FFFF, 5'd2, 5'd6},
        '{"beq", 2'b00, 0, 0, 1, 1, 32'h3C, 32'h0, 32'h1234, 5'd2});
    add('{0, 2'b10, 3'b000, 0, 1, 2'b11, 32'h0, 32'h7FFF_FFFF, 32'h55,
          32'h1, 5'd7, 5'd1},
        '{"addi_ovf", 2'b10, 0, 0, 0, 0, 32'h4, 32'h8000_0000, 32'h55,
          5'd7});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0, 32'h3, 32'h4,
          32'h3F, 5'd1, 5'd13},
        '{"funct_dflt", 2'b10, 0, 0, 0, 0, 32'hFC, 32'h7, 32'h4,
          5'd13});
    add('{0, 2'b00, 3'b010, 0, 1, 2'b00, 32'h0, 32'h10, 32'hCAFE,
          32'h8, 5'd14, 5'd15},
        '{"sw", 2'b00, 0, 1, 0, 0, 32'h20, 32'h18, 32'hCAFE, 5'd14});
    add('{0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0, 32'h1, 32'hFFFF_FFFF,
          32'h2A, 5'd1, 5'd16},
        '{"slt_signed", 2'b10, 0, 0, 0, 1, 32'hA8, 32'h0,
          32'hFFFF_FFFF, 5'd16});
    add('{1, 2'b11, 3'b111, 1, 0, 2'b10, 32'h8, 32'h1, 32'h2,
          32'h20, 5'd1, 5'd17},
        '{"rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0});

    foreach (vi[i]) issue(vi[i], ve[i]);

    for (int c = 0; c < 5 && sb.size() > 0; c++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name:
ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, sitting between the ID/EX register and the data memory.
- Contains the ALU-control decoder, the ALU operand-B mux, the 32-bit ALU, the destination-register mux and the branch-target adder.
- Also contains the EX/MEM pipeline register, which captures all results for the MEM stage.

Parameters:
- none (datapath fixed at 32 bits, register index 5 bits)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wb_in  in  2  WB controls {reg_write, mem_to_reg}
- mem_in  in  3  MEM controls {mem_read, mem_write, branch}
- reg_dst  in  1  1 = destination is rd, 0 = destination is rt
- alu_src  in  1  1 = operand B is imm_ext, 0 = operand B is read_data2
- alu_op  in  2  ALU operation class from the main control unit
- pc_plus4  in  32  PC+4 of the instruction
- read_data1  in  32  rs value (operand A)
- read_data2  in  32  rt value
- imm_ext  in  32  sign-extended immediate; bits [5:0] carry funct
- rt  in  5  instruction bits [20:16]
- rd  in  5  instruction bits [15:11]
- wb_out  out  2  registered wb_in
- mem_read_out  out  1  registered mem_in[2]
- mem_write_out  out  1  registered mem_in[1]
- branch_out  out  1  registered mem_in[0]
- zero_out  out  1  registered ALU zero flag
- branch_target_out  out  32  registered pc_plus4 + (imm_ext << 2)
- alu_result_out  out  32  registered ALU result
- write_data_out  out  32  registered read_data2 (store data)
- dest_reg_out  out  5  registered destination register index

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- While rst=1 at a rising edge, every registered output becomes 0.
- All logic in front of the EX/MEM register is combinational.
- Every input is captured at each rising edge with rst=0, so latency is exactly 1 cycle. There is no stall or enable.

ALU control mapping, alu_op → 3-bit ctrl:
- alu_op 00 → 010 (ADD; lw/sw)
- alu_op 01 → 110 (SUB; beq)
- alu_op 11 → 010 (ADD; addi)
- alu_op 10 decodes funct = imm_ext[5:0]:
  - 100000 → 010 ADD
  - 100010 → 110 SUB
  - 100100 → 000 AND
  - 100101 → 001 OR
  - 101010 → 111 SLT
  - 100111 → 100 NOR
  - any other funct → 010 ADD

ALU operations (A = read_data1, B = alu_src ? imm_ext : read_data2):
- ADD/SUB: two's complement, result truncated to 32 bits, overflow ignored (no trap, no flag).
- AND, OR, NOR: bitwise.
- SLT: signed compare; result = 32'd1 if A < B, else 0.
- Undefined ctrl codes (011, 101): result 0.
- Zero flag = (result == 0), computed combinationally, then registered.

Other datapath:
- Destination register: reg_dst ? rd : rt.
- Branch target: pc_plus4 + {imm_ext[29:0], 2'b00}, mod 2^32 (wrap-around allowed).
- Store data: read_data2 passes through unchanged, independent of alu_src.

Scope boundary:
- PC-source selection (branch_out & zero_out) is done outside this block.

Decomposition:
- Shared package `mips_pkg` holds:
  - ALU ctrl constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_NOR=3'b100, ALU_SUB=3'b110, ALU_SLT=3'b111
  - ALUOP_* codes
  - FUNCT_* codes
- One sub-module: `alu_core`, a combinational ALU taking (a, b, ctrl) and producing (result, zero).
- ALU-control decode, the muxes, the branch adder and the EX/MEM register stay inline.

Test Plan:
- Reset: drive nonzero inputs with rst=1 for 2 edges → all outputs 0; release rst → next edge captures the inputs.
- R-type ADD: alu_op=10, funct=100000, A=5, B=7, alu_src=0, reg_dst=1, rd=3 → alu_result_out=12, zero_out=0, dest_reg_out=3.
- R-type SUB/SLT/AND/OR/NOR with A=32'hFFFF_FFFF (-1), B=1:
  - SUB → 32'hFFFF_FFFE
  - SLT → 1
  - AND → 1
  - OR → 32'hFFFF_FFFF
  - NOR → 0 with zero_out=1
- lw: alu_op=00, alu_src=1, A=32'h100, imm_ext=32'hFFFF_FFFC, reg_dst=0, rt=9, wb_in=2'b11, mem_in=3'b100 → alu_result_out=32'hFC, dest_reg_out=9, mem_read_out=1, wb_out=11.
- beq taken: alu_op=01, A=B=32'h1234, pc_plus4=32'h40, imm_ext=32'hFFFF_FFFF, mem_in=3'b001 → zero_out=1, branch_out=1, branch_target_out=32'h3C.
- Pipelining: change inputs every cycle for 4 back-to-back ops → each output reflects the previous cycle's inputs. Add overflow case 32'h7FFF_FFFF+1 → 32'h8000_0000, with write_data_out=read_data2 throughout.
